vending_buyer: RTL and testbench

//  Purchase initiator that drives the Vending machine's customer port (MI/sel/re) and collects its response (MO/PO).

---
 rtl/vending_pkg.sv | 19 +
 rtl/vending_buyer_if.sv | 32 +++
 rtl/vending_coin_pick.sv | 20 ++
 rtl/vending_buyer.sv | 117 +++++++++++
 tb/tb_vending_buyer.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared types and constants for the vending buyer
package vending_pkg;

  localparam int DATA_W     = 8;
  localparam int COIN_A_DEF = 50;
  localparam int COIN_B_DEF = 10;
  localparam int COIN_C_DEF = 5;

  typedef enum logic [2:0] {
    IDLE,
    INSERT,
    SELECT,
    WAIT,
    REFUND,
    RWAIT,
    DONE
  } buyer_state_e;

endpackage

// File: rtl/vending_buyer_if.sv
// rtl/vending_buyer_if.sv - order, vending machine and result signals of the buyer
interface vending_buyer_if;

  logic                          req_valid;
  logic                          req_ready;
  logic [1:0]                    req_sel;
  logic [vending_pkg::DATA_W-1:0] req_amount;

  logic [vending_pkg::DATA_W-1:0] MI;
  logic [1:0]                    sel;
  logic                          re;
  logic [vending_pkg::DATA_W-1:0] MO;
  logic [1:0]                    PO;

  logic                          done;
  logic                          done_ok;
  logic [vending_pkg::DATA_W-1:0] done_change;
  logic [1:0]                    done_product;

  // buyer side
  modport master (
    input  req_valid, req_sel, req_amount, MO, PO,
    output req_ready, MI, sel, re, done, done_ok, done_change, done_product
  );

  // ordering logic and vending machine side
  modport slave (
    output req_valid, req_sel, req_amount, MO, PO,
    input  req_ready, MI, sel, re, done, done_ok, done_change, done_product
  );

endinterface

// File: rtl/vending_coin_pick.sv
// rtl/vending_coin_pick.sv - largest coin not exceeding the remaining amount
module vending_coin_pick #(
  parameter int DATA_W = 8,
  parameter int COIN_A = 50,
  parameter int COIN_B = 10,
  parameter int COIN_C = 5
) (
  input  logic [DATA_W-1:0] rem,
  output logic [DATA_W-1:0] coin
);

  // priority pick from the largest coin down; 1 covers everything below COIN_C
  always_comb begin
    coin = DATA_W'(1);
    if (rem >= DATA_W'(COIN_A))      coin = DATA_W'(COIN_A);
    else if (rem >= DATA_W'(COIN_B)) coin = DATA_W'(COIN_B);
    else if (rem >= DATA_W'(COIN_C)) coin = DATA_W'(COIN_C);
  end

endmodule

// File: rtl/vending_buyer.sv
// rtl/vending_buyer.sv - purchase initiator driving the vending machine customer port
module vending_buyer
  import vending_pkg::*;
#(
  parameter int COIN_A = COIN_A_DEF,
  parameter int COIN_B = COIN_B_DEF,
  parameter int COIN_C = COIN_C_DEF
) (
  input logic             clk,
  input logic             rst,
  vending_buyer_if.master bus
);

  buyer_state_e      state;
  buyer_state_e      state_nx;
  logic [1:0]        sel_r;
  logic [DATA_W-1:0] rem_r;
  logic [DATA_W-1:0] coin;

  vending_coin_pick #(
    .DATA_W (DATA_W),
    .COIN_A (COIN_A),
    .COIN_B (COIN_B),
    .COIN_C (COIN_C)
  ) u_coin_pick (
    .rem  (rem_r),
    .coin (coin)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next state; outputs decode from registered state only so no input reaches an output
  always_comb begin
    state_nx      = state;
    bus.req_ready = 1'b0;
    bus.MI        = '0;
    bus.sel       = 2'd0;
    bus.re        = 1'b0;
    bus.done      = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (bus.req_amount != '0)  state_nx = INSERT;
          else if (bus.req_sel != 0) state_nx = SELECT;
          else                       state_nx = REFUND;
        end
      end
      INSERT: begin
        bus.MI = coin;
        if (rem_r == coin) state_nx = (sel_r != 2'd0) ? SELECT : REFUND;
      end
      SELECT: begin
        bus.sel  = sel_r;
        state_nx = WAIT;
      end
      WAIT: begin
        // any product other than the one asked for is a failed purchase
        state_nx = (bus.PO == sel_r) ? DONE : REFUND;
      end
      REFUND: begin
        bus.re   = 1'b1;
        state_nx = RWAIT;
      end
      RWAIT: begin
        state_nx = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // order latch, remaining amount and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_r            <= 2'd0;
      rem_r            <= '0;
      bus.done_ok      <= 1'b0;
      bus.done_change  <= '0;
      bus.done_product <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            sel_r            <= bus.req_sel;
            rem_r            <= bus.req_amount;
            bus.done_ok      <= 1'b0;
            bus.done_change  <= '0;
            bus.done_product <= 2'd0;
          end
        end
        INSERT: rem_r <= rem_r - coin;
        WAIT: begin
          if (bus.PO == sel_r) begin
            bus.done_ok      <= 1'b1;
            bus.done_change  <= bus.MO;
            bus.done_product <= bus.PO;
          end
        end
        RWAIT: begin
          bus.done_ok      <= 1'b0;
          bus.done_change  <= bus.MO;
          bus.done_product <= 2'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vending_buyer.sv
// tb/tb_vending_buyer.sv - directed self-checking bench for vending_buyer
module tb_vending_buyer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  // vending machine stand-in: prices 30/15/0, optional wrong product injection
  logic [7:0] credit;
  logic [1:0] force_po = 2'd0;

  int done_a, done_b, acc_b, mi_sum, early_mi, n_done, prod_b;

  vending_buyer_if bus ();

  vending_buyer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] price(input logic [1:0] s);
    case (s)
      2'd1:    price = 8'd30;
      2'd2:    price = 8'd15;
      default: price = 8'd0;
    endcase
  endfunction

  // machine response: updates MO/PO at the closing edge of the buyer's request cycle
  always @(posedge clk) begin
    if (rst) begin
      credit <= 8'd0;
      bus.MO <= 8'd0;
      bus.PO <= 2'd0;
    end else begin
      bus.MO <= 8'd0;
      bus.PO <= 2'd0;
      if (bus.re) begin
        bus.MO <= credit;
        credit <= 8'd0;
      end else if (bus.sel != 2'd0) begin
        if (force_po != 2'd0) begin
          bus.PO <= force_po;
        end else if (credit >= price(bus.sel)) begin
          bus.PO <= bus.sel;
          bus.MO <= credit - price(bus.sel);
          credit <= 8'd0;
        end
      end else begin
        credit <= credit + bus.MI;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // coins are packed first coin in the low byte
  task automatic run_order(input string tag, input logic [1:0] s, input logic [7:0] amt,
                           input logic [63:0] coins, input int ncoins, input int exp_lat,
                           input int exp_sel_cyc, input int exp_re_cyc, input logic exp_ok,
                           input logic [7:0] exp_chg, input logic [1:0] exp_prod);
    int n, sel_cyc, re_cyc, lat;
    logic       got_ok;
    logic [7:0] got_chg;
    logic [1:0] got_prod;
    n = 0; sel_cyc = 0; re_cyc = 0; lat = 0;
    got_ok = 1'b0; got_chg = 8'd0; got_prod = 2'd0;
    @(negedge clk);
    check({tag, "_ready"}, bus.req_ready, 1);
    bus.req_valid  = 1'b1;
    bus.req_sel    = s;
    bus.req_amount = amt;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus.MI != 8'd0) begin
        if (n < ncoins) check($sformatf("%s_coin%0d", tag, n), bus.MI, coins[8*n +: 8]);
        n++;
      end
      if (bus.sel != 2'd0) begin
        sel_cyc++;
        check({tag, "_sel"}, bus.sel, s);
      end
      if (bus.re) re_cyc++;
      if (bus.done) begin
        lat      = k;
        got_ok   = bus.done_ok;
        got_chg  = bus.done_change;
        got_prod = bus.done_product;
        break;
      end
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_ncoins"}, n, ncoins);
    check({tag, "_sel_cycles"}, sel_cyc, exp_sel_cyc);
    check({tag, "_re_cycles"}, re_cyc, exp_re_cyc);
    check({tag, "_ok"}, got_ok, exp_ok);
    check({tag, "_change"}, got_chg, exp_chg);
    check({tag, "_product"}, got_prod, exp_prod);
    @(negedge clk);
    check({tag, "_done_pulse"}, bus.done, 0);
    check({tag, "_hold_change"}, bus.done_change, exp_chg);
    check({tag, "_idle_ready"}, bus.req_ready, 1);
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_sel    = 2'd0;
    bus.req_amount = 8'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", bus.req_ready, 1);
    check("rst_mi", bus.MI, 0);
    check("rst_sel", bus.sel, 0);
    check("rst_re", bus.re, 0);
    check("rst_done", bus.done, 0);
    check("rst_ok", bus.done_ok, 0);
    check("rst_change", bus.done_change, 0);
    check("rst_product", bus.done_product, 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    run_order("buy37", 2'd1, 8'd37, {8'd1, 8'd1, 8'd5, 8'd10, 8'd10, 8'd10}, 6, 9, 1, 0, 1'b1, 8'd7, 2'd1);
    run_order("short20", 2'd1, 8'd20, {8'd10, 8'd10}, 2, 7, 1, 1, 1'b0, 8'd20, 2'd0);
    run_order("free0", 2'd3, 8'd0, 64'd0, 0, 3, 1, 0, 1'b1, 8'd0, 2'd3);
    run_order("refund55", 2'd0, 8'd55, {8'd5, 8'd50}, 2, 5, 0, 1, 1'b0, 8'd55, 2'd0);
    run_order("refund0", 2'd0, 8'd0, 64'd0, 0, 3, 0, 1, 1'b0, 8'd0, 2'd0);
    run_order("buy255", 2'd2, 8'd255, {8'd5, 8'd50, 8'd50, 8'd50, 8'd50, 8'd50}, 6, 9, 1, 0, 1'b1, 8'd240, 2'd2);
    run_order("short4", 2'd2, 8'd4, {8'd1, 8'd1, 8'd1, 8'd1}, 4, 9, 1, 1, 1'b0, 8'd4, 2'd0);
    force_po = 2'd2;
    run_order("wrongpo", 2'd1, 8'd30, {8'd10, 8'd10, 8'd10}, 3, 8, 1, 1, 1'b0, 8'd30, 2'd0);
    force_po = 2'd0;

    // reset during the second coin
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_sel    = 2'd1;
    bus.req_amount = 8'd37;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst_coin2", bus.MI, 10);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_mi", bus.MI, 0);
    check("midrst_sel", bus.sel, 0);
    check("midrst_re", bus.re, 0);
    check("midrst_ready", bus.req_ready, 1);
    rst = 1'b0;
    n_done = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check("midrst_no_done", n_done, 0);

    // back-to-back orders with req_valid held
    done_a = 0; done_b = 0; acc_b = 0; mi_sum = 0; early_mi = 0; n_done = 0; prod_b = 0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_sel    = 2'd3;
    bus.req_amount = 8'd0;
    @(posedge clk);
    #1;
    bus.req_sel    = 2'd1;
    bus.req_amount = 8'd37;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (acc_b != 0 && c == acc_b + 1) bus.req_valid = 1'b0;
      if (bus.done) begin
        n_done++;
        if (done_a == 0) done_a = c;
        else if (done_b == 0) begin
          done_b = c;
          prod_b = int'(bus.done_product);
        end
      end
      if (bus.req_ready && done_a != 0 && acc_b == 0) acc_b = c;
      if (bus.MI != 8'd0 && acc_b == 0) early_mi++;
      mi_sum += int'(bus.MI);
    end
    check("hold_done_a", done_a, 3);
    check("hold_accept_b", acc_b, 4);
    check("hold_done_b", done_b, 13);
    check("hold_early_mi", early_mi, 0);
    check("hold_mi_sum", mi_sum, 37);
    check("hold_n_done", n_done, 2);
    check("hold_product_b", prod_b, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
